// File: rtl/ibex_ex_seq_ctrl_if.sv
// Issue / writeback / datapath-enable bundle between the ID stage, the
// execute-stage sequencing controller and the execute datapath.
// The controller side uses the slave modport. The driving side (ID stage,
// datapath and writeback) uses the master modport.
interface ibex_ex_seq_ctrl_if #(
    parameter int CntW = 6
);
    logic            issue_valid_i;
    logic [1:0]      issue_op_i;
    logic            issue_ready_o;
    logic            flush_i;
    logic            ex_valid_i;
    logic            wb_ready_i;
    logic            result_valid_o;
    logic            alu_first_cycle_o;
    logic            mult_en_o;
    logic            div_en_o;
    logic            mult_sel_o;
    logic            div_sel_o;
    logic            multdiv_ready_id_o;
    logic            busy_o;
    logic [CntW-1:0] cycle_cnt_o;
    logic            wdog_err_o;

    modport slave (
        input  issue_valid_i, issue_op_i, flush_i, ex_valid_i, wb_ready_i,
        output issue_ready_o, result_valid_o, alu_first_cycle_o, mult_en_o,
               div_en_o, mult_sel_o, div_sel_o, multdiv_ready_id_o, busy_o,
               cycle_cnt_o, wdog_err_o
    );

    modport master (
        output issue_valid_i, issue_op_i, flush_i, ex_valid_i, wb_ready_i,
        input  issue_ready_o, result_valid_o, alu_first_cycle_o, mult_en_o,
               div_en_o, mult_sel_o, div_sel_o, multdiv_ready_id_o, busy_o,
               cycle_cnt_o, wdog_err_o
    );
endinterface

// File: rtl/ibex_ex_seq_ctrl.sv
// Execute-stage sequencing controller.
// Turns one issued instruction into per-cycle datapath enables. It tracks
// multi-cycle completion, hands the result to writeback with a valid/ready
// handshake, and spends one KILL cycle after a flush so the multdiv unit can
// return to idle.
// Optional watchdog: define IBEX_EX_SEQ_CTRL_WDOG_EN to flag an operation that
// sits in EXEC for MaxCycles cycles. The flag is sticky until reset.
module ibex_ex_seq_ctrl #(
    parameter int CntW      = 6,
    parameter int MaxCycles = 40
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    ibex_ex_seq_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_KILL = 2'b10
    } state_e;

    localparam logic [1:0] OP_MULT = 2'b10;
    localparam logic [1:0] OP_DIV  = 2'b11;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [1:0]      r_op;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_nxt;
    logic [1:0]      w_cur_op;
    logic            w_fire;
    logic            w_latch_op;

    // A watchdog threshold the counter can never reach is a configuration error.
    if (MaxCycles >= (1 << CntW)) begin : g_cfg_check
        $error("MaxCycles must be below 2**CntW");
    end

    // Operation currently being steered: the incoming one while idle, else the latched one.
    assign w_cur_op = (r_state == ST_IDLE) ? bus.issue_op_i : r_op;
    assign w_fire   = bus.issue_valid_i & ~bus.flush_i;

    // Next-state, per-cycle enables and next counter value.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt            = r_state;
        w_cnt_nxt              = r_cnt;
        w_latch_op             = 1'b0;
        bus.issue_ready_o      = 1'b0;
        bus.result_valid_o     = 1'b0;
        bus.alu_first_cycle_o  = 1'b0;
        bus.mult_en_o          = 1'b0;
        bus.div_en_o           = 1'b0;
        bus.multdiv_ready_id_o = 1'b0;
        bus.mult_sel_o         = (r_state != ST_KILL) && (w_cur_op == OP_MULT);
        bus.div_sel_o          = (r_state != ST_KILL) && (w_cur_op == OP_DIV);

        unique case (r_state)
            ST_IDLE: begin
                bus.issue_ready_o = 1'b1;
                w_cnt_nxt         = '0;
                if (w_fire) begin
                    w_latch_op             = 1'b1;
                    bus.alu_first_cycle_o  = 1'b1;
                    bus.mult_en_o          = (bus.issue_op_i == OP_MULT);
                    bus.div_en_o           = (bus.issue_op_i == OP_DIV);
                    bus.multdiv_ready_id_o = bus.wb_ready_i;
                    if (bus.ex_valid_i && bus.wb_ready_i) begin
                        // Zero-latency completion: result retires in the issue cycle.
                        bus.result_valid_o = 1'b1;
                    end else begin
                        w_state_nxt = ST_EXEC;
                        w_cnt_nxt   = CntW'(1);
                    end
                end
            end
            ST_EXEC: begin
                // Enables stay up while writeback stalls so the datapath holds its result.
                bus.mult_en_o          = (r_op == OP_MULT);
                bus.div_en_o           = (r_op == OP_DIV);
                bus.multdiv_ready_id_o = bus.wb_ready_i;
                w_cnt_nxt              = (r_cnt == '1) ? r_cnt : r_cnt + CntW'(1);
                if (bus.flush_i) begin
                    w_state_nxt = ST_KILL;
                end else if (bus.ex_valid_i && bus.wb_ready_i) begin
                    bus.result_valid_o = 1'b1;
                    w_state_nxt        = ST_IDLE;
                    w_cnt_nxt          = '0;
                end
            end
            ST_KILL: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, latched operation and cycle counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= ST_IDLE;
            r_op    <= 2'b00;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch_op) begin
                r_op <= bus.issue_op_i;
            end
        end
    end

    assign bus.busy_o      = (r_state != ST_IDLE);
    assign bus.cycle_cnt_o = r_cnt;

`ifdef IBEX_EX_SEQ_CTRL_WDOG_EN
    logic r_wdog;

    // Sticky watchdog: set once an operation has spent MaxCycles cycles in EXEC.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wdog <= 1'b0;
        end else if ((r_state == ST_EXEC) && (r_cnt == CntW'(MaxCycles))) begin
            r_wdog <= 1'b1;
        end
    end

    assign bus.wdog_err_o = r_wdog;
`else
    assign bus.wdog_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_ibex_ex_seq_ctrl.sv
// Self-checking bench for ibex_ex_seq_ctrl.
// It has three parts: a table of single-issue vectors applied from reset,
// hand-written multi-cycle sequences, and randomized traffic compared with a
// behavioural model.
module tb_ibex_ex_seq_ctrl;
    localparam int CntW      = 6;
    localparam int MaxCycles = 40;
    localparam int CntMax    = (1 << CntW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ibex_ex_seq_ctrl_if #(.CntW(CntW)) bus ();

    ibex_ex_seq_ctrl #(.CntW(CntW), .MaxCycles(MaxCycles)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // {issue_ready, result_valid, first, mult_en, div_en, mult_sel, div_sel, md_ready, busy, wdog}
    function automatic logic [9:0] outs();
        return {bus.issue_ready_o, bus.result_valid_o, bus.alu_first_cycle_o, bus.mult_en_o,
                bus.div_en_o, bus.mult_sel_o, bus.div_sel_o, bus.multdiv_ready_id_o,
                bus.busy_o, bus.wdog_err_o};
    endfunction

    task automatic drive(input logic v, input logic [1:0] op, input logic f,
                         input logic exv, input logic wbr);
        bus.issue_valid_i = v;
        bus.issue_op_i    = op;
        bus.flush_i       = f;
        bus.ex_valid_i    = exv;
        bus.wb_ready_i    = wbr;
    endtask

    // Behavioural model: is an op outstanding, is a kill slot pending, and how old is the op.
    bit m_inflight, m_killing, m_err;
    int m_op, m_age;

    task automatic model_reset();
        m_inflight = 0; m_killing = 0; m_err = 0; m_op = 0; m_age = 0;
    endtask

    function automatic logic [15:0] model_out(input logic v, input int op, input logic f,
                                             input logic exv, input logic wbr);
        logic ir, rv, first, me, de, ms, ds, mdr, busy;
        {ir, rv, first, me, de, ms, ds, mdr} = '0;
        busy = m_inflight || m_killing;
        if (m_killing) begin
            // nothing asserts in the kill slot
        end else if (!m_inflight) begin
            ir    = 1;
            first = v && !f;
            me    = first && (op == 2);
            de    = first && (op == 3);
            ms    = (op == 2);
            ds    = (op == 3);
            mdr   = first && wbr;
            rv    = first && exv && wbr;
        end else begin
            me  = (m_op == 2);
            de  = (m_op == 3);
            ms  = me;
            ds  = de;
            mdr = wbr;
            rv  = exv && wbr && !f;
        end
        return {ir, rv, first, me, de, ms, ds, mdr, busy, m_err, 6'(m_age)};
    endfunction

    task automatic model_step(input logic v, input int op, input logic f,
                              input logic exv, input logic wbr);
`ifdef IBEX_EX_SEQ_CTRL_WDOG_EN
        if (m_inflight && m_age == MaxCycles) m_err = 1;
`endif
        if (m_killing) begin
            m_killing = 0;
            m_age     = 0;
        end else if (!m_inflight) begin
            if (v && !f && !(exv && wbr)) begin
                m_inflight = 1;
                m_op       = op;
                m_age      = 1;
            end
        end else begin
            m_age = (m_age >= CntMax) ? CntMax : m_age + 1;
            if (f) begin
                m_inflight = 0;
                m_killing  = 1;
            end else if (exv && wbr) begin
                m_inflight = 0;
                m_age      = 0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 2'b00, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic            v;
        logic [1:0]      op;
        logic            f;
        logic            exv;
        logic            wbr;
        logic [9:0]      exp;
        logic            busy_n;
        logic [CntW-1:0] cnt_n;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic wbr;
        logic exp_w;
        drive(0, 2'b00, 0, 0, 0);

        vecs[0] = '{v:0, op:2'b00, f:0, exv:0, wbr:0, exp:10'b1000000000, busy_n:0, cnt_n:0};
        vecs[1] = '{v:1, op:2'b00, f:0, exv:1, wbr:1, exp:10'b1110000100, busy_n:0, cnt_n:0};
        vecs[2] = '{v:1, op:2'b10, f:0, exv:0, wbr:1, exp:10'b1011010100, busy_n:1, cnt_n:1};
        vecs[3] = '{v:1, op:2'b11, f:0, exv:0, wbr:0, exp:10'b1010101000, busy_n:1, cnt_n:1};
        vecs[4] = '{v:1, op:2'b10, f:1, exv:0, wbr:1, exp:10'b1000010000, busy_n:0, cnt_n:0};
        vecs[5] = '{v:1, op:2'b01, f:0, exv:1, wbr:0, exp:10'b1010000000, busy_n:1, cnt_n:1};
        vecs[6] = '{v:0, op:2'b11, f:0, exv:1, wbr:1, exp:10'b1000001000, busy_n:0, cnt_n:0};
        vecs[7] = '{v:1, op:2'b11, f:0, exv:1, wbr:1, exp:10'b1110101100, busy_n:0, cnt_n:0};

        // Single-issue vectors from a fresh reset: same-cycle outputs, then next-cycle busy/count.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            @(negedge clk);
            drive(vecs[i].v, vecs[i].op, vecs[i].f, vecs[i].exv, vecs[i].wbr);
            #1;
            check($sformatf("vec%0d outs", i), 32'(outs()), 32'(vecs[i].exp));
            @(negedge clk);
            drive(0, 2'b00, 0, 0, 0);
            #1;
            check($sformatf("vec%0d busy/cnt", i), 32'({bus.busy_o, bus.cycle_cnt_o}),
                  32'({vecs[i].busy_n, vecs[i].cnt_n}));
        end

        // Mult with writeback backpressure on cycles 3-5.
        do_reset();
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            wbr = !(c >= 3 && c <= 5);
            drive(c == 0, 2'b10, 0, c >= 3, wbr);
            #1;
            check($sformatf("mult_en c%0d", c), 32'(bus.mult_en_o), 32'(1));
            check($sformatf("mult rv c%0d", c), 32'(bus.result_valid_o), 32'(c == 6));
            check($sformatf("mult mdr c%0d", c), 32'(bus.multdiv_ready_id_o), 32'(wbr));
            check($sformatf("mult cnt c%0d", c), 32'(bus.cycle_cnt_o), 32'(c));
        end
        @(negedge clk);
        drive(0, 2'b00, 0, 0, 0);
        #1;
        check("mult done busy", 32'(bus.busy_o), 32'(0));

        // Div flushed on cycle 10 together with a completing result.
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            drive(c == 0, 2'b11, c == 10, c == 10, c == 10);
            #1;
            if (c == 10) begin
                check("flush rv", 32'(bus.result_valid_o), 32'(0));
                check("flush div_en held", 32'(bus.div_en_o), 32'(1));
            end else if (c == 11) begin
                check("kill slot", 32'({bus.busy_o, bus.div_en_o, bus.div_sel_o,
                                         bus.issue_ready_o, bus.result_valid_o}), 32'(5'b10000));
            end else if (c == 12) begin
                check("after kill", 32'({bus.busy_o, bus.issue_ready_o, bus.cycle_cnt_o}),
                      32'({1'b0, 1'b1, 6'd0}));
            end
        end

        // Asynchronous reset in the middle of a div.
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            drive(c == 0, 2'b11, 0, 0, 0);
            #1;
        end
        check("pre-reset busy/cnt", 32'({bus.busy_o, bus.cycle_cnt_o}), 32'({1'b1, 6'd5}));
        rst_n = 1'b0;
        #1;
        check("async reset", 32'({bus.busy_o, bus.div_en_o, bus.cycle_cnt_o, bus.wdog_err_o}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Long div without completion: counter saturation and watchdog behaviour.
        do_reset();
        for (int c = 0; c <= 72; c++) begin
            @(negedge clk);
            drive(c == 0, 2'b11, c == 70, 0, 1);
            #1;
`ifdef IBEX_EX_SEQ_CTRL_WDOG_EN
            exp_w = (c > MaxCycles);
`else
            exp_w = 1'b0;
`endif
            if (c >= 1 && c <= 70) begin
                check($sformatf("long div c%0d", c), 32'({bus.cycle_cnt_o, bus.wdog_err_o}),
                      32'({6'((c > CntMax) ? CntMax : c), exp_w}));
            end else if (c > 70) begin
                check($sformatf("post flush c%0d", c), 32'({bus.busy_o, bus.wdog_err_o}),
                      32'({c == 71, exp_w}));
            end
        end

        // Randomized traffic against the behavioural model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic v, f, exv;
            logic [1:0] op;
            @(negedge clk);
            v   = ($urandom % 100) < 50;
            op  = 2'($urandom);
            f   = ($urandom % 100) < 8;
            exv = ($urandom % 100) < 30;
            wbr = ($urandom % 100) < 70;
            drive(v, op, f, exv, wbr);
            #1;
            check($sformatf("rand%0d", i), 32'({outs(), bus.cycle_cnt_o}),
                  32'(model_out(v, int'(op), f, exv, wbr)));
            model_step(v, int'(op), f, exv, wbr);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
